seq_multi_operand_adder: RTL and testbench



---
 rtl/seq_multi_operand_adder.sv | 82 ++++++++
 tb/tb_seq_multi_operand_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multi_operand_adder.sv
// Sequential multi-operand adder: streams NUM_OPS unsigned operands through a
// valid/ready port, adds a one-time carry-in, and hands back the wide sum.
module seq_multi_operand_adder #(
  parameter  int WIDTH   = 7,
  parameter  int NUM_OPS = 8,
  localparam int ACC_W   = WIDTH + $clog2(NUM_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ci,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic [ACC_W-1:0] sum_full,
  output logic             busy
);
  localparam int CNT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // start is only looked at in IDLE, so pulses during ACCUM/DONE fall through
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = ACC_W'(ci);
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          acc_d = acc_q + ACC_W'(in_data);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ACC_W > WIDTH always holds, so the overflow slice is never empty
  assign sum      = acc_q[WIDTH-1:0];
  assign co       = |acc_q[ACC_W-1:WIDTH];
  assign sum_full = acc_q;

endmodule

// File: tb/tb_seq_multi_operand_adder.sv
// Bench for seq_multi_operand_adder: default build driven from a vector table,
// plus two extra parameterisations checked against a reference sum.
module tb_seq_multi_operand_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default build: WIDTH=7, NUM_OPS=8, ACC_W=11
  logic        a_start = 0, a_ci = 0, a_in_valid = 0, a_out_ready = 0;
  logic [6:0]  a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_co, a_busy;
  logic [6:0]  a_sum;
  logic [10:0] a_sum_full;
  // WIDTH=4, NUM_OPS=1, ACC_W=5
  logic        b_start = 0, b_ci = 0, b_in_valid = 0, b_out_ready = 0;
  logic [3:0]  b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_co, b_busy;
  logic [3:0]  b_sum;
  logic [4:0]  b_sum_full;
  // WIDTH=16, NUM_OPS=13, ACC_W=20
  logic        c_start = 0, c_ci = 0, c_in_valid = 0, c_out_ready = 0;
  logic [15:0] c_in_data = '0;
  logic        c_in_ready, c_out_valid, c_co, c_busy;
  logic [15:0] c_sum;
  logic [19:0] c_sum_full;

  seq_multi_operand_adder u_a (
    .clk(clk), .rst(rst), .start(a_start), .ci(a_ci), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sum(a_sum), .co(a_co), .sum_full(a_sum_full), .busy(a_busy));

  seq_multi_operand_adder #(.WIDTH(4), .NUM_OPS(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .ci(b_ci), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sum(b_sum), .co(b_co), .sum_full(b_sum_full), .busy(b_busy));

  seq_multi_operand_adder #(.WIDTH(16), .NUM_OPS(13)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .ci(c_ci), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .sum(c_sum), .co(c_co), .sum_full(c_sum_full), .busy(c_busy));

  typedef struct {
    logic            ci;
    logic [7:0][6:0] ops;
    int              stall_max;
    int              hold;
    bit              glitch;
    logic [10:0]     exp_full;
  } vec_t;

  int npass = 0, ntot = 0;
  logic [63:0] q_a[$], q_b[$], q_c[$];
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full default-build transaction; expected value queued when driving starts
  task automatic run_a(input vec_t v, input string nm);
    int cyc;
    logic [63:0] exp;
    chk({nm, "/idle_busy"}, 64'(a_busy), 64'd0);
    q_a.push_back(64'(v.exp_full));
    a_start = 1; a_ci = v.ci;
    tick(); cyc = 2;
    a_start = 0;
    chk({nm, "/in_ready"}, 64'(a_in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      int st;
      st = (v.stall_max > 0) ? int'($urandom_range(v.stall_max, 0)) : 0;
      for (int s = 0; s < st; s++) begin
        a_in_valid = 0; a_in_data = 7'h55; a_start = v.glitch;
        tick(); cyc++;
      end
      a_in_valid = 1; a_in_data = v.ops[i]; a_start = v.glitch;
      tick(); cyc++;
    end
    a_in_valid = 0; a_start = 0;
    for (int w = 0; w < 20 && !a_out_valid; w++) begin tick(); cyc++; end
    chk({nm, "/out_valid"}, 64'(a_out_valid), 64'd1);
    if (v.stall_max == 0) chk({nm, "/latency"}, 64'(cyc), 64'd10);
    for (int h = 0; h < v.hold; h++) begin
      a_start = v.glitch;
      tick();
      chk({nm, "/hold_full"}, 64'(a_sum_full), 64'(v.exp_full));
      chk({nm, "/hold_valid"}, 64'(a_out_valid), 64'd1);
    end
    chk({nm, "/done_in_ready"}, 64'(a_in_ready), 64'd0);
    exp = (q_a.size() > 0) ? q_a.pop_front() : 64'hdead;
    chk({nm, "/sum_full"}, 64'(a_sum_full), exp);
    chk({nm, "/sum"}, 64'(a_sum), exp & 64'h7f);
    chk({nm, "/co"}, 64'(a_co), 64'((exp >> 7) != 0));
    a_out_ready = 1; a_start = v.glitch;
    tick();
    a_out_ready = 0; a_start = 0;
    chk({nm, "/post_busy"}, 64'(a_busy), 64'd0);
    chk({nm, "/post_valid"}, 64'(a_out_valid), 64'd0);
  endtask

  function automatic vec_t mk(input logic ci, input int kind, input int stall, input int hold,
                              input bit glitch, input logic [10:0] exp_full);
    vec_t v;
    v.ci = ci; v.stall_max = stall; v.hold = hold; v.glitch = glitch; v.exp_full = exp_full;
    for (int i = 0; i < 8; i++)
      case (kind)
        0: v.ops[i] = 7'(i + 1);
        1: v.ops[i] = 7'd127;
        2: v.ops[i] = 7'(10 * (i + 1));
        3: v.ops[i] = 7'd1;
        default: v.ops[i] = 7'($urandom_range(127, 0));
      endcase
    if (kind > 3) begin
      int s;
      s = int'(ci);
      for (int i = 0; i < 8; i++) s += int'(v.ops[i]);
      v.exp_full = 11'(s);
    end
    return v;
  endfunction

  task automatic run_b(input int n);
    for (int t = 0; t < n; t++) begin
      logic [63:0] exp;
      bit forced;
      forced = (t == 0);
      b_ci = forced ? 1'b1 : 1'($urandom_range(1, 0));
      b_in_data = forced ? 4'hf : 4'($urandom_range(15, 0));
      q_b.push_back(64'(b_ci) + 64'(b_in_data));
      b_start = 1; tick(); b_start = 0;
      b_in_valid = 1; tick(); b_in_valid = 0;
      for (int w = 0; w < 10 && !b_out_valid; w++) tick();
      chk("b/out_valid", 64'(b_out_valid), 64'd1);
      exp = (q_b.size() > 0) ? q_b.pop_front() : 64'hdead;
      chk("b/sum_full", 64'(b_sum_full), exp);
      chk("b/sum", 64'(b_sum), exp & 64'hf);
      chk("b/co", 64'(b_co), 64'((exp >> 4) != 0));
      b_out_ready = 1; tick(); b_out_ready = 0;
    end
  endtask

  task automatic run_c(input int n);
    for (int t = 0; t < n; t++) begin
      logic [63:0] exp, model;
      bit forced;
      forced = (t == 0);
      c_ci = forced ? 1'b1 : 1'($urandom_range(1, 0));
      model = 64'(c_ci);
      c_start = 1; tick(); c_start = 0;
      for (int i = 0; i < 13; i++) begin
        int st;
        st = int'($urandom_range(2, 0));
        for (int s = 0; s < st; s++) begin c_in_valid = 0; tick(); end
        c_in_data = forced ? 16'hffff : 16'($urandom_range(65535, 0));
        model += 64'(c_in_data);
        c_in_valid = 1; tick();
      end
      c_in_valid = 0;
      q_c.push_back(model);
      for (int w = 0; w < 10 && !c_out_valid; w++) tick();
      chk("c/out_valid", 64'(c_out_valid), 64'd1);
      exp = (q_c.size() > 0) ? q_c.pop_front() : 64'hdead;
      chk("c/sum_full", 64'(c_sum_full), exp);
      chk("c/sum", 64'(c_sum), exp & 64'hffff);
      chk("c/co", 64'(c_co), 64'((exp >> 16) != 0));
      c_out_ready = 1; tick(); c_out_ready = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    tick(); tick();
    chk("rst/in_ready", 64'(a_in_ready), 64'd0);
    chk("rst/out_valid", 64'(a_out_valid), 64'd0);
    chk("rst/busy", 64'(a_busy), 64'd0);
    chk("rst/sum_full", 64'(a_sum_full), 64'd0);
    chk("rst/co", 64'(a_co), 64'd0);
    rst = 0;
    tick();

    tbl.push_back(mk(1'b0, 0, 0, 0, 1'b0, 11'd36));    // 1..8
    tbl.push_back(mk(1'b1, 1, 0, 5, 1'b0, 11'd1017));  // all 127 + ci, held
    tbl.push_back(mk(1'b0, 2, 3, 0, 1'b0, 11'd360));   // backpressure
    tbl.push_back(mk(1'b0, 0, 2, 2, 1'b1, 11'd36));    // start pulses while busy
    tbl.push_back(mk(1'b1, 4, 1, 1, 1'b0, 11'd0));     // random
    tbl.push_back(mk(1'b0, 5, 3, 0, 1'b1, 11'd0));     // random
    for (int k = 0; k < tbl.size(); k++) run_a(tbl[k], $sformatf("v%0d", k));

    // abort mid-accumulation
    a_start = 1; a_ci = 1; tick(); a_start = 0;
    for (int i = 0; i < 4; i++) begin a_in_valid = 1; a_in_data = 7'd100; tick(); end
    a_in_valid = 0;
    rst = 1; tick(); rst = 0;
    chk("abort/busy", 64'(a_busy), 64'd0);
    chk("abort/in_ready", 64'(a_in_ready), 64'd0);
    chk("abort/out_valid", 64'(a_out_valid), 64'd0);
    chk("abort/sum_full", 64'(a_sum_full), 64'd0);
    chk("abort/sum", 64'(a_sum), 64'd0);
    chk("abort/co", 64'(a_co), 64'd0);
    tick();
    chk("abort/no_pulse", 64'(a_out_valid), 64'd0);
    run_a(mk(1'b0, 3, 0, 0, 1'b0, 11'd8), "ones");

    run_b(6);
    run_c(4);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
